// File: rtl/melody_player_if.sv
// melody_player_if
// ----------------
// Bundles the register/config side and the audio side of the melody player so
// the sequencer and whatever drives it share one typed connection.
//
// Macro: none here (the player itself honours MELODY_GAP_EN).
//
// Signals:
//   wrEn_i       table write strobe
//   wrAddr_i     table write address (AW bits)
//   wrData_i     table entry: [BW-1:0] half-period divider, [DW+BW-1:BW] duration code
//   start_i      start/restart playback pulse
//   stop_i       abort playback pulse
//   loop_i       level, wrap to entry 0 after the last note
//   lastIndex_i  index of the final note
//   tempo_i      clock cycles per tempo tick (0 behaves as 1)
//   tone_o       square-wave output
//   busy_o       playback active
//   noteIndex_o  index of the note currently playing
//   done_o       one-cycle pulse when non-looping playback ends
//
// Modports: slave = the player, master = the controller driving it.

interface melody_player_if #(
    parameter int BW = 16,
    parameter int AW = 6,
    parameter int DW = 2,
    parameter int TW = 24
);
    logic                wrEn_i;
    logic [AW-1:0]       wrAddr_i;
    logic [DW+BW-1:0]    wrData_i;
    logic                start_i;
    logic                stop_i;
    logic                loop_i;
    logic [AW-1:0]       lastIndex_i;
    logic [TW-1:0]       tempo_i;
    logic                tone_o;
    logic                busy_o;
    logic [AW-1:0]       noteIndex_o;
    logic                done_o;

    modport slave (
        input  wrEn_i, wrAddr_i, wrData_i, start_i, stop_i, loop_i, lastIndex_i, tempo_i,
        output tone_o, busy_o, noteIndex_o, done_o
    );

    modport master (
        output wrEn_i, wrAddr_i, wrData_i, start_i, stop_i, loop_i, lastIndex_i, tempo_i,
        input  tone_o, busy_o, noteIndex_o, done_o
    );
endinterface

// File: rtl/melody_player.sv
// melody_player
// -------------
// Writable note table plus playback sequencer. Each table entry holds a
// half-period divider (0 = rest) and a duration code; a tempo tick counter
// walks through the entries and the divider drives a square-wave tone.
//
// Optional feature macro: MELODY_GAP_EN
//   defined   - notes with duration code >= 1 are silenced during their final
//               tick to give an audible articulation gap between notes
//   undefined - no gap logic; tone_o only low for rests and when idle
//
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset (table contents are kept)
//   bus    melody_player_if.slave carrying write port, playback controls and
//          tone/busy/noteIndex/done outputs

module melody_player #(
    parameter int BW = 16,
    parameter int AW = 6,
    parameter int DW = 2,
    parameter int TW = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    melody_player_if.slave    bus
);

    typedef enum logic {IDLE, PLAY} state_e;

    logic [DW+BW-1:0] tableQ [2**AW];

    state_e           stateQ,   stateD;
    logic [AW-1:0]    idxQ,     idxD;
    logic [BW-1:0]    divQ,     divD;
    logic [DW-1:0]    durQ,     durD;
    logic [BW-1:0]    phaseQ,   phaseD;
    logic [TW-1:0]    tickQ,    tickD;
    logic [DW-1:0]    tickNumQ, tickNumD;
    logic             toneQ,    toneD;
    logic             doneQ,    doneD;

    logic [TW-1:0]    tickLen;
    logic             tickEnd;
    logic             noteEnd;
    logic             loadNote;
    logic [AW-1:0]    loadIdx;
    logic [DW+BW-1:0] loadEntry;

    // Note table is deliberately not reset; writes are accepted in any state.
    always_ff @(posedge clk_i) begin
        if (bus.wrEn_i) begin
            tableQ[bus.wrAddr_i] <= bus.wrData_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ   <= IDLE;
            idxQ     <= '0;
            divQ     <= '0;
            durQ     <= '0;
            phaseQ   <= '0;
            tickQ    <= '0;
            tickNumQ <= '0;
            toneQ    <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            idxQ     <= idxD;
            divQ     <= divD;
            durQ     <= durD;
            phaseQ   <= phaseD;
            tickQ    <= tickD;
            tickNumQ <= tickNumD;
            toneQ    <= toneD;
            doneQ    <= doneD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        idxD      = idxQ;
        divD      = divQ;
        durD      = durQ;
        phaseD    = phaseQ;
        tickD     = tickQ;
        tickNumD  = tickNumQ;
        toneD     = toneQ;
        doneD     = 1'b0;
        loadNote  = 1'b0;
        loadIdx   = '0;
        loadEntry = '0;

        // Tempo is sampled live; a zero tempo behaves as one cycle per tick.
        tickLen = (bus.tempo_i == '0) ? TW'(1) : bus.tempo_i;
        tickEnd = (tickQ == tickLen - TW'(1));
        noteEnd = tickEnd && (tickNumQ == durQ);

        // Stop outranks start so an abort can never be lost to a restart.
        if (bus.stop_i) begin
            stateD = IDLE;
            toneD  = 1'b0;
        end else if (bus.start_i) begin
            loadNote = 1'b1;
            loadIdx  = '0;
            stateD   = PLAY;
        end else if (stateQ == PLAY) begin
            if (noteEnd) begin
                if (idxQ != bus.lastIndex_i) begin
                    loadNote = 1'b1;
                    loadIdx  = idxQ + AW'(1);
                end else if (bus.loop_i) begin
                    loadNote = 1'b1;
                    loadIdx  = '0;
                end else begin
                    stateD = IDLE;
                    doneD  = 1'b1;
                    toneD  = 1'b0;
                end
            end else begin
                tickD = tickEnd ? '0 : tickQ + TW'(1);
                if (tickEnd) begin
                    tickNumD = tickNumQ + DW'(1);
                end
                // A zero divider is a rest: phase counter parks, tone stays low.
                if (divQ == '0) begin
                    toneD = 1'b0;
                end else if (phaseQ == divQ - BW'(1)) begin
                    phaseD = '0;
                    toneD  = ~toneQ;
                end else begin
                    phaseD = phaseQ + BW'(1);
                end
            end
        end

        // Divider and duration are latched here, so rewriting the entry that
        // is playing only matters the next time that entry is started.
        if (loadNote) begin
            loadEntry = tableQ[loadIdx];
            idxD      = loadIdx;
            divD      = loadEntry[BW-1:0];
            durD      = loadEntry[DW+BW-1:BW];
            phaseD    = '0;
            tickD     = '0;
            tickNumD  = '0;
            toneD     = 1'b0;
        end
    end

`ifdef MELODY_GAP_EN
    logic gapActive;
    // Final tick of a multi-tick note is muted; toneQ keeps running underneath.
    assign gapActive   = (stateQ == PLAY) && (durQ != '0) && (tickNumQ == durQ);
    assign bus.tone_o  = toneQ & ~gapActive;
`else
    assign bus.tone_o  = toneQ;
`endif

    assign bus.busy_o      = (stateQ == PLAY);
    assign bus.noteIndex_o = idxQ;
    assign bus.done_o      = doneQ;

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player
// ----------------
// Self-checking bench for melody_player. Expected per-cycle outputs are derived
// from the note table contents held by the bench and pushed onto a scoreboard
// queue when playback is kicked off; each cycle one record is popped and
// compared one time unit after the rising edge.

module tb_melody_player;

    localparam int BW = 16;
    localparam int AW = 6;
    localparam int DW = 2;
    localparam int TW = 24;

    typedef struct {
        logic          tone;
        logic          busy;
        logic [AW-1:0] idx;
        logic          done;
        bit            chkIdx;
    } exp_t;

    typedef struct {
        int div;
        int dur;
        int tempo;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    melody_player_if #(.BW(BW), .AW(AW), .DW(DW), .TW(TW)) bus ();

    melody_player #(.BW(BW), .AW(AW), .DW(DW), .TW(TW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t  sb[$];
    int    modelDiv[2**AW];
    int    modelDur[2**AW];
    int    curT;
    int    checks = 0;
    int    fails  = 0;
    int    recNo  = 0;
    string testName = "reset";

    function automatic logic toneAt(int div, int dur, int t, int c);
        if (div == 0) return 1'b0;
`ifdef MELODY_GAP_EN
        if (dur >= 1 && c >= dur * t) return 1'b0;
`endif
        return ((c / div) % 2) == 1;
    endfunction

    function automatic exp_t mkExp(logic tone, logic busy, int idx, logic done, bit chk);
        exp_t e;
        e.tone   = tone;
        e.busy   = busy;
        e.idx    = AW'(idx);
        e.done   = done;
        e.chkIdx = chk;
        return e;
    endfunction

    // Expected playback from note 0 onward, at most 'limit' playing cycles;
    // a non-looping run that finishes also gets its done and idle records.
    task automatic pushPlay(int lastIdx, bit loopOn, int limit);
        int cnt = 0;
        int n   = 0;
        while (cnt < limit) begin
            int len = (modelDur[n] + 1) * curT;
            for (int c = 0; c < len && cnt < limit; c++) begin
                sb.push_back(mkExp(toneAt(modelDiv[n], modelDur[n], curT, c), 1'b1, n, 1'b0, 1'b1));
                cnt++;
            end
            if (cnt >= limit) break;
            if (n == lastIdx) begin
                if (loopOn) begin
                    n = 0;
                end else begin
                    sb.push_back(mkExp(1'b0, 1'b0, lastIdx, 1'b1, 1'b1));
                    sb.push_back(mkExp(1'b0, 1'b0, lastIdx, 1'b0, 1'b1));
                    break;
                end
            end else begin
                n++;
            end
        end
    endtask

    task automatic checkOutput(exp_t e);
        logic ok;
        checks++;
        ok = (bus.tone_o === e.tone) && (bus.busy_o === e.busy) && (bus.done_o === e.done)
             && (!e.chkIdx || bus.noteIndex_o === e.idx);
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s rec%0d: got tone=%b busy=%b idx=%0d done=%b, want tone=%b busy=%b idx=%0d done=%b",
                     testName, recNo, bus.tone_o, bus.busy_o, bus.noteIndex_o, bus.done_o,
                     e.tone, e.busy, e.idx, e.done);
        end
        recNo++;
    endtask

    task automatic stepCheck();
        @(posedge clk);
        #1;
        if (sb.size() > 0) checkOutput(sb.pop_front());
    endtask

    task automatic drain();
        while (sb.size() > 0) stepCheck();
    endtask

    task automatic applyStimulus(bit st, bit sp);
        bus.start_i = st;
        bus.stop_i  = sp;
        stepCheck();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
    endtask

    task automatic writeEntry(int addr, int dur, int div);
        bus.wrEn_i   = 1'b1;
        bus.wrAddr_i = AW'(addr);
        bus.wrData_i = {DW'(dur), BW'(div)};
        @(posedge clk);
        #1;
        bus.wrEn_i   = 1'b0;
        modelDiv[addr] = div;
        modelDur[addr] = dur;
    endtask

    task automatic setTempo(int t);
        bus.tempo_i = TW'(t);
        curT = (t == 0) ? 1 : t;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{div: 4, dur: 0, tempo: 20, name: "single_div4_t20"};
        vecs[1] = '{div: 1, dur: 0, tempo: 0,  name: "tempo0_one_cycle"};
        vecs[2] = '{div: 1, dur: 3, tempo: 0,  name: "tempo0_toggle_each"};
        vecs[3] = '{div: 3, dur: 1, tempo: 5,  name: "div3_dur1_t5"};
        vecs[4] = '{div: 0, dur: 2, tempo: 4,  name: "rest_dur2_t4"};
        vecs[5] = '{div: 2, dur: 1, tempo: 8,  name: "gap_div2_dur1_t8"};

        bus.wrEn_i      = 1'b0;
        bus.wrAddr_i    = '0;
        bus.wrData_i    = '0;
        bus.start_i     = 1'b0;
        bus.stop_i      = 1'b0;
        bus.loop_i      = 1'b0;
        bus.lastIndex_i = '0;
        setTempo(20);

        // Reset state, checked while reset is still asserted.
        rst = 1'b1;
        @(posedge clk);
        sb.push_back(mkExp(1'b0, 1'b0, 0, 1'b0, 1'b1));
        stepCheck();
        rst = 1'b0;

        // Single-note vectors.
        foreach (vecs[i]) begin
            testName = vecs[i].name;
            recNo = 0;
            writeEntry(0, vecs[i].dur, vecs[i].div);
            bus.lastIndex_i = '0;
            bus.loop_i = 1'b0;
            setTempo(vecs[i].tempo);
            pushPlay(0, 1'b0, 100000);
            applyStimulus(1'b1, 1'b0);
            drain();
        end

        // Three-note melody, no loop.
        writeEntry(0, 1, 3);
        writeEntry(1, 0, 0);
        writeEntry(2, 0, 5);
        setTempo(10);
        bus.lastIndex_i = AW'(2);
        bus.loop_i = 1'b0;
        testName = "three_notes";
        recNo = 0;
        pushPlay(2, 1'b0, 100000);
        applyStimulus(1'b1, 1'b0);
        drain();

        // Looping, then stop in the middle of note 0 while tone is high.
        bus.loop_i = 1'b1;
        testName = "loop_then_stop";
        recNo = 0;
        pushPlay(2, 1'b1, 95);
        applyStimulus(1'b1, 1'b0);
        drain();
        sb.push_back(mkExp(1'b0, 1'b0, 0, 1'b0, 1'b0));
        sb.push_back(mkExp(1'b0, 1'b0, 0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b1);
        drain();

        // Start and stop together while busy: stop wins.
        bus.loop_i = 1'b0;
        testName = "start_stop_same";
        recNo = 0;
        pushPlay(2, 1'b0, 7);
        applyStimulus(1'b1, 1'b0);
        drain();
        sb.push_back(mkExp(1'b0, 1'b0, 0, 1'b0, 1'b0));
        sb.push_back(mkExp(1'b0, 1'b0, 0, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b1);
        drain();

        // Restart while playing index 2, then let it run to done.
        testName = "restart_at_idx2";
        recNo = 0;
        pushPlay(2, 1'b0, 35);
        applyStimulus(1'b1, 1'b0);
        drain();
        pushPlay(2, 1'b0, 100000);
        applyStimulus(1'b1, 1'b0);
        drain();

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
